// File: rtl/ode_ram_pkg.sv
// Shared definitions for the four-bank ODE RAM and its stream clients:
// word width, per-bank address widths and heights, and the reader FSM states.
package ode_ram_pkg;

    localparam int unsigned DATA_WIDTH        = 64;

    localparam int unsigned BANK1_ADDR_WIDTH  = 10;
    localparam int unsigned BANK2_ADDR_WIDTH  = 12;
    localparam int unsigned BANK3_ADDR_WIDTH  = 12;
    localparam int unsigned BANK4_ADDR_WIDTH  = 7;

    localparam int unsigned BANK1_HEIGHT      = 918;
    localparam int unsigned BANK2_HEIGHT      = 2500;
    localparam int unsigned BANK3_HEIGHT      = 2500;
    localparam int unsigned BANK4_HEIGHT      = 69;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } stream_state_t;

endpackage

// File: rtl/ram_stream_fifo2.sv
// Two-entry synchronous FIFO used as the skid buffer behind the RAM read port.
// Pop requests on an empty FIFO are ignored; the head word is always visible.
module ram_stream_fifo2 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side stream client for one ODE RAM bank. On start it reads `count`
// sequential words from `base_addr` (wrapping) and streams them out over a
// valid/ready interface through a 2-entry skid buffer.
// Optional: define RAM_STREAM_CHECKSUM_EN to add the XOR `checksum` output.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH    = ode_ram_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = ode_ram_pkg::BANK1_ADDR_WIDTH,
    parameter int unsigned COUNT_WIDTH   = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [COUNT_WIDTH-1:0]   count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_wr,
    output logic [DATA_WIDTH-1:0]    ram_data_write,
    input  logic [DATA_WIDTH-1:0]    ram_data_read,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef RAM_STREAM_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    import ode_ram_pkg::*;

    stream_state_t            r_state;
    stream_state_t            w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic [COUNT_WIDTH-1:0]   r_issued;
    logic                     r_issue_q;
    logic [ADDRESS_WIDTH-1:0] r_addr;

    logic                     w_issue;
    logic [ADDRESS_WIDTH-1:0] w_issue_addr;
    logic                     w_accept_start;
    logic                     w_pop;
    logic [1:0]               w_fifo_count;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [2:0]               w_occupancy;

    assign w_accept_start = start && (r_state == IDLE);
    assign w_pop          = out_ready && !w_fifo_empty;
    // Words buffered plus in flight, after this cycle's pop.
    assign w_occupancy    = {1'b0, w_fifo_count} + {2'b00, r_issue_q} - {2'b00, w_pop};

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == FINISH);
    assign out_valid      = !w_fifo_empty;
    assign ram_wr         = 1'b0;
    assign ram_data_write = '0;
    // The first address is driven straight from base_addr in the start cycle so
    // that data lands in the FIFO in time for out_valid two cycles later.
    assign ram_address    = w_issue_addr;

    // Next-state, read-issue decision and presented RAM address.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_addr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_state_next = RUN;
                        w_issue      = 1'b1;
                        w_issue_addr = base_addr;
                    end else begin
                        w_state_next = FINISH;
                    end
                end
            end
            RUN: begin
                if ((r_issued < r_count) && (w_occupancy < 3'd2)) begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_base + ADDRESS_WIDTH'(r_issued);
                end
                if ((r_issued == r_count) && !r_issue_q && (w_fifo_count == 2'd1) && w_pop) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state, transfer parameters, issue counter and read pipeline flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_count   <= '0;
            r_issued  <= '0;
            r_issue_q <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_issue_q <= w_issue;
            if (w_issue) begin
                r_addr <= w_issue_addr;
            end
            if (w_accept_start) begin
                r_base   <= base_addr;
                r_count  <= count;
                r_issued <= (count != '0) ? COUNT_WIDTH'(1) : '0;
            end else if (w_issue) begin
                r_issued <= r_issued + COUNT_WIDTH'(1);
            end
        end
    end

    ram_stream_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_issue_q),
        .i_pop   (out_ready),
        .i_data  (ram_data_read),
        .o_data  (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The issue throttle guarantees a free slot for every returning read.
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_issue_q && w_fifo_full));

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    assign checksum = r_checksum;

    // XOR of every accepted word; cleared when a new transfer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept_start) begin
            r_checksum <= '0;
        end else if (out_valid && out_ready) begin
            r_checksum <= r_checksum ^ out_data;
        end
    end
`endif

endmodule
